// File: rtl/rv32_pkg.sv
// Shared RV32I constants: opcodes, ALU operation codes, write-back sources,
// branch funct3 codes and the default reset PC.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // Arithmetic/logic op select shared by OP and OP-IMM. SUB only exists
  // for the register form; SRA is selected by bit 30 in both forms.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                               input logic       bit30,
                                               input logic       is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Branch comparator: equality plus a less-than whose signedness is selected
// by the caller.
module br_cmp
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_unsigned,
  output logic        br_eq,
  output logic        br_lt
);

  // Equality and signed/unsigned ordering of the two operands.
  always_comb begin
    br_eq = (a == b);
    if (is_unsigned) begin
      br_lt = (a < b);
    end else begin
      br_lt = ($signed(a) < $signed(b));
    end
  end

endmodule

// File: rtl/riscv_fetch_decode.sv
// RV32I fetch/decode front end: program counter, instruction decoder and
// branch resolution. The PC is the only state; decode is combinational.
module riscv_fetch_decode
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] Addr,
  output logic [31:0] PC,
  output logic        PCSel,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        RegWE,
  output logic        MemWE,
  output logic [1:0]  WBSel,
  output logic [31:0] Imm,
  output logic [4:0]  ALUop,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        BrEq
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic        br_eq_s;
  logic        br_lt_s;
  logic        br_unsigned_s;
  logic        take_s;

  logic        pc_sel_s;
  logic        alu_src1_s;
  logic        alu_src2_s;
  logic        reg_we_s;
  logic        mem_we_s;
  wb_sel_e     wb_sel_s;
  alu_op_e     alu_op_s;
  logic [31:0] imm_sel_s;
  logic [31:0] pc_r;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign rd       = inst[11:7];

  assign imm_i_s = {{20{inst[31]}}, inst[31:20]};
  assign imm_s_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u_s = {inst[31:12], 12'h000};
  assign imm_j_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // BLTU/BGEU (funct3 11x) compare unsigned; BLT/BGE compare signed.
  assign br_unsigned_s = (funct3_s == F3_BLTU) || (funct3_s == F3_BGEU);

  br_cmp u_br_cmp (
    .a           (ReadData1),
    .b           (ReadData2),
    .is_unsigned (br_unsigned_s),
    .br_eq       (br_eq_s),
    .br_lt       (br_lt_s)
  );

  assign BrEq = br_eq_s;

  // Branch condition from funct3; 010/011 are not branches and never take.
  always_comb begin
    take_s = 1'b0;
    case (funct3_s)
      F3_BEQ:  take_s = br_eq_s;
      F3_BNE:  take_s = !br_eq_s;
      F3_BLT:  take_s = br_lt_s;
      F3_BGE:  take_s = !br_lt_s;
      F3_BLTU: take_s = br_lt_s;
      F3_BGEU: take_s = !br_lt_s;
      default: take_s = 1'b0;
    endcase
  end

  // Opcode decode into datapath controls; unknown opcodes decode as a NOP.
  always_comb begin
    pc_sel_s   = 1'b0;
    alu_src1_s = 1'b0;
    alu_src2_s = 1'b0;
    reg_we_s   = 1'b0;
    mem_we_s   = 1'b0;
    wb_sel_s   = WB_MEM;
    alu_op_s   = ALU_ADD;
    imm_sel_s  = 32'h0000_0000;
    case (opcode_s)
      OPC_OP: begin
        alu_op_s = alu_from_funct3(funct3_s, inst[30], 1'b1);
        reg_we_s = 1'b1;
        wb_sel_s = WB_ALU;
      end
      OPC_OP_IMM: begin
        alu_op_s   = alu_from_funct3(funct3_s, inst[30], 1'b0);
        alu_src2_s = 1'b1;
        reg_we_s   = 1'b1;
        wb_sel_s   = WB_ALU;
        imm_sel_s  = imm_i_s;
      end
      OPC_LOAD: begin
        alu_src2_s = 1'b1;
        reg_we_s   = 1'b1;
        wb_sel_s   = WB_MEM;
        imm_sel_s  = imm_i_s;
      end
      OPC_STORE: begin
        alu_src2_s = 1'b1;
        mem_we_s   = 1'b1;
        imm_sel_s  = imm_s_s;
      end
      OPC_BRANCH: begin
        alu_src1_s = 1'b1;
        alu_src2_s = 1'b1;
        pc_sel_s   = take_s;
        imm_sel_s  = imm_b_s;
      end
      OPC_JAL: begin
        alu_src1_s = 1'b1;
        alu_src2_s = 1'b1;
        reg_we_s   = 1'b1;
        wb_sel_s   = WB_PC4;
        pc_sel_s   = 1'b1;
        imm_sel_s  = imm_j_s;
      end
      OPC_JALR: begin
        alu_src2_s = 1'b1;
        reg_we_s   = 1'b1;
        wb_sel_s   = WB_PC4;
        pc_sel_s   = 1'b1;
        imm_sel_s  = imm_i_s;
      end
      OPC_LUI: begin
        alu_op_s   = ALU_PASSB;
        alu_src2_s = 1'b1;
        reg_we_s   = 1'b1;
        wb_sel_s   = WB_ALU;
        imm_sel_s  = imm_u_s;
      end
      OPC_AUIPC: begin
        alu_src1_s = 1'b1;
        alu_src2_s = 1'b1;
        reg_we_s   = 1'b1;
        wb_sel_s   = WB_ALU;
        imm_sel_s  = imm_u_s;
      end
      default: begin
        alu_op_s = ALU_ADD;
      end
    endcase
  end

  // Reset suppresses every side effect (writes and redirects) but leaves the
  // rest of the decode visible.
  always_comb begin
    ALUSrc1 = alu_src1_s;
    ALUSrc2 = alu_src2_s;
    WBSel   = wb_sel_s;
    ALUop   = alu_op_s;
    Imm     = imm_sel_s;
    if (rst) begin
      PCSel = 1'b0;
      RegWE = 1'b0;
      MemWE = 1'b0;
    end else begin
      PCSel = pc_sel_s;
      RegWE = reg_we_s;
      MemWE = mem_we_s;
    end
  end

  // Program counter: reset vector, word-aligned redirect, or sequential step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (PCSel) begin
      pc_r <= {Addr[31:2], 2'b00};
    end else begin
      pc_r <= pc_r + 32'd4;
    end
  end

  assign PC = pc_r;

endmodule

// File: tb/tb_riscv_fetch_decode.sv
// Self-checking bench for riscv_fetch_decode: directed test-plan steps
// followed by randomized instructions checked against a reference model.
module tb_riscv_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] Addr;
  logic [31:0] PC;
  logic        PCSel;
  logic        ALUSrc1;
  logic        ALUSrc2;
  logic        RegWE;
  logic        MemWE;
  logic [1:0]  WBSel;
  logic [31:0] Imm;
  logic [4:0]  ALUop;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        BrEq;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  riscv_fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .inst(inst), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .Addr(Addr), .PC(PC), .PCSel(PCSel),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .RegWE(RegWE), .MemWE(MemWE),
    .WBSel(WBSel), .Imm(Imm), .ALUop(ALUop), .rs1(rs1), .rs2(rs2),
    .rd(rd), .BrEq(BrEq)
  );

  typedef struct packed {
    logic        pcsel;
    logic        src1;
    logic        src2;
    logic        regwe;
    logic        memwe;
    logic [1:0]  wb;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        breq;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                 input logic [31:0] b, input logic r);
    exp_t e;
    int f3;
    int alu_tab[8];
    logic signed [31:0] si;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic eq, slt, ult, take;
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    e  = '0;
    f3 = int'(i[14:12]);
    si = $signed(i);
    imm_i = 32'(si >>> 20);
    imm_s = 32'((si >>> 25) <<< 5) | 32'(i[11:7]);
    imm_b = 32'((si >>> 31) <<< 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    imm_u = i & 32'hFFFF_F000;
    imm_j = 32'((si >>> 31) <<< 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    eq  = (a == b);
    slt = ($signed(a) < $signed(b));
    ult = (a < b);
    e.breq = eq;
    case (f3)
      0: take = eq;
      1: take = !eq;
      4: take = slt;
      5: take = !slt;
      6: take = ult;
      7: take = !ult;
      default: take = 1'b0;
    endcase
    case (i[6:0])
      7'b0110011, 7'b0010011: begin
        e.alu = 5'(alu_tab[f3]);
        if (f3 == 5 && i[30]) e.alu = 5'd7;
        if (i[5] && f3 == 0 && i[30]) e.alu = 5'd1;
        e.src2 = !i[5];
        e.imm = i[5] ? 32'd0 : imm_i;
        e.regwe = 1'b1; e.wb = 2'd1;
      end
      7'b0000011: begin e.src2 = 1'b1; e.regwe = 1'b1; e.wb = 2'd0; e.imm = imm_i; end
      7'b0100011: begin e.src2 = 1'b1; e.memwe = 1'b1; e.imm = imm_s; end
      7'b1100011: begin e.src1 = 1'b1; e.src2 = 1'b1; e.pcsel = take; e.imm = imm_b; end
      7'b1101111: begin e.src1 = 1'b1; e.src2 = 1'b1; e.regwe = 1'b1; e.wb = 2'd2; e.pcsel = 1'b1; e.imm = imm_j; end
      7'b1100111: begin e.src2 = 1'b1; e.regwe = 1'b1; e.wb = 2'd2; e.pcsel = 1'b1; e.imm = imm_i; end
      7'b0110111: begin e.alu = 5'd10; e.src2 = 1'b1; e.regwe = 1'b1; e.wb = 2'd1; e.imm = imm_u; end
      7'b0010111: begin e.src1 = 1'b1; e.src2 = 1'b1; e.regwe = 1'b1; e.wb = 2'd1; e.imm = imm_u; end
      default: e = '{breq: eq, default: '0};
    endcase
    if (r) begin
      e.pcsel = 1'b0; e.regwe = 1'b0; e.memwe = 1'b0;
    end
    return e;
  endfunction

  task automatic check_all(input string tag);
    exp_t e;
    e = model(inst, ReadData1, ReadData2, rst);
    chk({tag, ".PCSel"},   32'(PCSel),   32'(e.pcsel));
    chk({tag, ".ALUSrc1"}, 32'(ALUSrc1), 32'(e.src1));
    chk({tag, ".ALUSrc2"}, 32'(ALUSrc2), 32'(e.src2));
    chk({tag, ".RegWE"},   32'(RegWE),   32'(e.regwe));
    chk({tag, ".MemWE"},   32'(MemWE),   32'(e.memwe));
    chk({tag, ".WBSel"},   32'(WBSel),   32'(e.wb));
    chk({tag, ".Imm"},     Imm,          e.imm);
    chk({tag, ".ALUop"},   32'(ALUop),   32'(e.alu));
    chk({tag, ".BrEq"},    32'(BrEq),    32'(e.breq));
    chk({tag, ".rs1"},     32'(rs1),     32'(inst[19:15]));
    chk({tag, ".rs2"},     32'(rs2),     32'(inst[24:20]));
    chk({tag, ".rd"},      32'(rd),      32'(inst[11:7]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc_m;
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  opc_list [9];
    exp_t        e;
    opc_list = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    // Reset then sequential fetch
    rst = 1'b1; inst = NOP; ReadData1 = 32'd0; ReadData2 = 32'd0; Addr = 32'h0000_0100;
    #1;
    chk("rst_regwe", 32'(RegWE), 32'd0);
    chk("rst_pcsel", 32'(PCSel), 32'd0);
    tick();
    chk("pc_reset", PC, 32'h0);
    rst = 1'b0;
    #1;
    chk("nop_regwe", 32'(RegWE), 32'd1);
    tick(); chk("pc_seq4", PC, 32'h4);
    tick(); chk("pc_seq8", PC, 32'h8);

    // ADDI x1,x0,5
    inst = 32'h0050_0093; #1;
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_rs1", 32'(rs1), 32'd0);
    chk("addi_imm", Imm, 32'd5);
    chk("addi_alu", 32'(ALUop), 32'd0);
    chk("addi_src2", 32'(ALUSrc2), 32'd1);
    chk("addi_regwe", 32'(RegWE), 32'd1);
    chk("addi_wb", 32'(WBSel), 32'd1);
    chk("addi_pcsel", 32'(PCSel), 32'd0);
    tick(); chk("pc_c", PC, 32'hC);

    // SUB x3,x1,x2
    inst = 32'h4020_81B3; #1;
    chk("sub_rd", 32'(rd), 32'd3);
    chk("sub_rs1", 32'(rs1), 32'd1);
    chk("sub_rs2", 32'(rs2), 32'd2);
    chk("sub_alu", 32'(ALUop), 32'd1);
    chk("sub_src1", 32'(ALUSrc1), 32'd0);
    chk("sub_src2", 32'(ALUSrc2), 32'd0);
    chk("sub_regwe", 32'(RegWE), 32'd1);

    // SW x2,4(x1)
    inst = 32'h0020_A223; #1;
    chk("sw_imm", Imm, 32'd4);
    chk("sw_memwe", 32'(MemWE), 32'd1);
    chk("sw_regwe", 32'(RegWE), 32'd0);
    tick(); chk("pc_10", PC, 32'h10);

    // BEQ not taken at PC=0x10
    inst = 32'h0020_8463; ReadData1 = 32'd7; ReadData2 = 32'd8; Addr = 32'h18; #1;
    chk("beq_ne_breq", 32'(BrEq), 32'd0);
    chk("beq_ne_pcsel", 32'(PCSel), 32'd0);
    tick(); chk("beq_ne_pc", PC, 32'h14);

    // JAL x1,16 redirecting back to 0x10
    inst = 32'h0100_00EF; Addr = 32'h10; #1;
    chk("jal_imm", Imm, 32'd16);
    chk("jal_wb", 32'(WBSel), 32'd2);
    chk("jal_regwe", 32'(RegWE), 32'd1);
    chk("jal_pcsel", 32'(PCSel), 32'd1);
    tick(); chk("jal_pc", PC, 32'h10);

    // BEQ taken at PC=0x10
    inst = 32'h0020_8463; ReadData2 = 32'd7; Addr = 32'h18; #1;
    chk("beq_eq_breq", 32'(BrEq), 32'd1);
    chk("beq_eq_pcsel", 32'(PCSel), 32'd1);
    chk("beq_eq_imm", Imm, 32'd8);
    tick(); chk("beq_eq_pc", PC, 32'h18);

    // Misaligned redirect to the top of memory, then PC+4 wraps to zero
    Addr = 32'hFFFF_FFFF; #1;
    tick(); chk("redirect_align", PC, 32'hFFFF_FFFC);
    inst = NOP; #1;
    tick(); chk("pc_wrap", PC, 32'h0);

    // JAL to 0x20, then reset mid-run
    inst = 32'h0100_00EF; Addr = 32'h20; #1;
    tick(); chk("jal_to_20", PC, 32'h20);
    rst = 1'b1; #1;
    chk("midrst_pcsel", 32'(PCSel), 32'd0);
    chk("midrst_regwe", 32'(RegWE), 32'd0);
    chk("midrst_imm", Imm, 32'd16);
    tick(); chk("midrst_pc", PC, 32'h0);
    rst = 1'b0;
    pc_m = 32'h0;

    // Randomized instructions against the reference model
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      if ($urandom_range(0, 9) == 0) opc = r[6:0];
      else opc = opc_list[$urandom_range(0, 8)];
      inst = {r[31:7], opc};
      ReadData1 = $urandom();
      case ($urandom_range(0, 3))
        0: ReadData2 = ReadData1;
        1: ReadData2 = ~ReadData1;
        2: ReadData2 = ReadData1 ^ 32'h8000_0000;
        default: ReadData2 = $urandom();
      endcase
      Addr = $urandom();
      rst  = ($urandom_range(0, 19) == 0);
      #1;
      check_all("rand");
      e = model(inst, ReadData1, ReadData2, rst);
      if (rst) pc_m = 32'h0;
      else if (e.pcsel) pc_m = {Addr[31:2], 2'b00};
      else pc_m = pc_m + 32'd4;
      tick();
      chk("rand.PC", PC, pc_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_decode.md
# riscv_fetch_decode

Fetch/decode front end of the single-cycle RV32I core. It holds the program counter, decodes the 32-bit instruction returned by the instruction memory into datapath controls and a sign-extended immediate, and compares the two register-file read operands to resolve branches. It sits between the instruction memory and register file on one side and the ALU, data memory and write-back mux on the other. The program counter is its only state.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `inst`  in  32  instruction at the current `PC`, from the instruction memory.
- `ReadData1`  in  32  register-file value of `rs1`.
- `ReadData2`  in  32  register-file value of `rs2`.
- `Addr`  in  32  redirect target, the ALU result (PC+imm or rs1+imm).
- `PC`  out  32  current program counter.
- `PCSel`  out  1  1 = the next PC is `Addr`; 0 = the next PC is PC+4.
- `ALUSrc1`  out  1  ALU operand A select: 0 = rs1, 1 = PC.
- `ALUSrc2`  out  1  ALU operand B select: 0 = rs2, 1 = Imm.
- `RegWE`  out  1  register-file write enable.
- `MemWE`  out  1  data-memory write enable.
- `WBSel`  out  2  write-back source: 0 = memory, 1 = ALU, 2 = PC+4. Value 3 is never driven.
- `Imm`  out  32  sign-extended immediate.
- `ALUop`  out  5  ALU operation code.
- `rs1`, `rs2`, `rd`  out  5 each  register fields `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `BrEq`  out  1  1 when `ReadData1 == ReadData2`.

## Operation

- **PC register**
  - Each rising edge: `PC <= rst ? RESET_PC : (PCSel ? {Addr[31:2],2'b00} : PC + 4)`.
  - PC+4 wraps modulo 2^32.
- **Branch comparator**
  - `BrEq` = equality of the two read operands.
  - Internal `BrLt` is computed signed for funct3 100/101 and unsigned for funct3 110/111.
- **Immediate formats**
  - I: `inst[31:20]`.
  - S: `{inst[31:25], inst[11:7]}`.
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U: `{inst[31:12], 12'b0}`.
  - J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
  - I, S, B and J are sign-extended from bit 31. `Imm` = 0 for R-type and illegal opcodes.
- **ALUop encoding**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - Codes 11–31 are unused.
- **Decode per opcode**
  - OP (0110011): register-register. funct3 and `inst[30]` select ALUop. `RegWE=1`, `WBSel=1`, `ALUSrc1=0`, `ALUSrc2=0`.
  - OP-IMM (0010011): as OP with `ALUSrc2=1`. `inst[30]` selects SRA only for funct3=101.
  - LOAD (0000011): ADD, `ALUSrc2=1`, `RegWE=1`, `WBSel=0`.
  - STORE (0100011): ADD, `ALUSrc2=1`, `MemWE=1`.
  - BRANCH (1100011): ADD, `ALUSrc1=1`, `ALUSrc2=1`.
    - `PCSel` = BEQ: BrEq; BNE: !BrEq; BLT/BLTU: BrLt; BGE/BGEU: !BrLt.
    - funct3 010/011 never take the branch.
  - JAL (1101111): ADD, `ALUSrc1=1`, `ALUSrc2=1`, `RegWE=1`, `WBSel=2`, `PCSel=1`.
  - JALR (1100111): as JAL with `ALUSrc1=0`.
  - LUI (0110111): PASSB, `ALUSrc2=1`, `RegWE=1`, `WBSel=1`.
  - AUIPC (0010111): ADD, `ALUSrc1=1`, `ALUSrc2=1`, `RegWE=1`, `WBSel=1`.
  - Any other opcode: NOP. All enables 0, `PCSel=0`, ALUop ADD.
- **Defaults**: any control not listed for an opcode is 0.
- **Reset gating**: while `rst=1`, `RegWE`, `MemWE` and `PCSel` are forced to 0. All other outputs keep decoding.

## Timing

- All decode and compare outputs are purely combinational from `inst`, `ReadData1/2` and `rst`. They have zero latency.
- `PC` changes only at the rising edge of `clk`. A redirect decided in cycle N appears on `PC` in cycle N+1.
- Reset mid-operation: the edge on which `rst` is sampled high loads `RESET_PC` and overrides `PCSel`. The first fetch after `rst` deasserts is from `RESET_PC`.
- Before the first reset edge, `PC` is undefined.

## Structure

- **Shared package `rv32_pkg`**: opcode constants, the ALUop enum, the WBSel enum, funct3 branch codes, and `RESET_PC` default.
- **Sub-module `br_cmp`**: the comparator, producing `BrEq` and `BrLt` with a signed/unsigned control.
- PC register and decoder are coded in the top module.

## Test plan

- **Reset then sequential fetch**: hold `rst=1` for one edge, then feed NOPs (0x00000013) → PC = 0, 4, 8 on successive edges; `RegWE=0` while `rst=1`.
- **ADDI**: `inst`=0x00500093 (addi x1,x0,5) → rd=1, rs1=0, Imm=5, ALUop=0, ALUSrc2=1, RegWE=1, WBSel=1, PCSel=0.
- **SUB**: `inst`=0x402081B3 (sub x3,x1,x2) → rd=3, rs1=1, rs2=2, ALUop=1, ALUSrc1=0, ALUSrc2=0, RegWE=1.
- **Store**: `inst`=0x0020A223 (sw x2,4(x1)) → Imm=4, MemWE=1, RegWE=0.
- **BEQ**: `inst`=0x00208463 (beq x1,x2,8).
  - ReadData1=ReadData2=7 → BrEq=1, PCSel=1, Imm=8; with PC=0x10 and Addr=0x18, next PC=0x18.
  - ReadData2=8 → BrEq=0, next PC=0x14.
- **JAL and mid-run reset**: `inst`=0x010000EF (jal x1,16) → Imm=16, WBSel=2, RegWE=1, PCSel=1. Asserting `rst` with PC=0x20 → PCSel=0 and next PC=0.
